// File: rtl/cov_stream_source_pkg.sv
// Shared constants and types for the covariance stream source.
package cov_stream_source_pkg;

    localparam int unsigned DEFAULT_NUM_INPUTS = 784;
    localparam int unsigned RD_LATENCY         = 1;
    localparam int unsigned DATA_W             = 32;
    localparam int unsigned STATE_W            = 2;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cov_stream_source_if.sv
// Sample-buffer read ports and x / mean / y output streams of the stream source.
// addr and rd_en act as the buffer's address register: read data is taken on the edge that ends the rd_en cycle.
interface cov_stream_source_if
    import cov_stream_source_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
);

    logic [ADDR_WIDTH-1:0] x_addr;
    logic [ADDR_WIDTH-1:0] y_addr;
    logic                  x_rd_en;
    logic                  y_rd_en;
    word_t                 x_rd_data;
    word_t                 y_rd_data;

    word_t                 in_x;
    logic                  in_x_valid;
    logic                  in_x_ready;
    word_t                 u_x;
    logic                  u_x_valid;
    word_t                 in_y;
    logic                  in_y_valid;
    logic                  in_y_ready;

    modport master (
        output x_addr, y_addr, x_rd_en, y_rd_en,
        input  x_rd_data, y_rd_data,
        output in_x, in_x_valid, u_x, u_x_valid, in_y, in_y_valid,
        input  in_x_ready, in_y_ready
    );

    modport slave (
        input  x_addr, y_addr, x_rd_en, y_rd_en,
        output x_rd_data, y_rd_data,
        input  in_x, in_x_valid, u_x, u_x_valid, in_y, in_y_valid,
        output in_x_ready, in_y_ready
    );

endinterface

// File: rtl/cov_stream_source_fetch_channel.sv
// One fetch channel: reads NUM_INPUTS words in address order into a 2-entry buffer
// and streams them out with a valid/ready handshake.
module stream_fetch_channel
    import cov_stream_source_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = DEFAULT_NUM_INPUTS,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  flush,
    input  logic                  run,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    input  word_t                 rd_data,
    output word_t                 data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  complete_c
);

    localparam int unsigned CNT_W = $clog2(NUM_INPUTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_INPUTS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_INPUTS - 1);

    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] xfer_q;
    logic             inflight_q;
    word_t            buf_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       occ_q;
    logic             pop_c;
    logic             issue_c;

    assign valid = (occ_q != 2'd0);
    assign data  = buf_q[rd_ptr_q];
    assign rd_en = inflight_q;
    assign pop_c = valid && ready;

    // Counting the same-cycle pop keeps one read per cycle flowing with ready held high.
    assign issue_c = run && (issued_q != CNT_MAX)
                     && ((occ_q + 2'(inflight_q)) < (2'd2 + 2'(pop_c)));

    // Complete on the edge of the final transfer so the FSM can leave RUN on that edge.
    assign complete_c = (xfer_q == CNT_MAX) || (pop_c && (xfer_q == CNT_LAST));

    always_ff @(posedge clk) begin
        if (clr) begin
            issued_q   <= '0;
            xfer_q     <= '0;
            inflight_q <= 1'b0;
            addr       <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else if (flush) begin
            // A new run restarts at address 0 and issues its first read immediately.
            issued_q   <= CNT_W'(1);
            xfer_q     <= '0;
            inflight_q <= 1'b1;
            addr       <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            inflight_q <= issue_c;
            if (issue_c) begin
                addr     <= ADDR_WIDTH'(issued_q);
                issued_q <= issued_q + CNT_W'(1);
            end
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= rd_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
                if (xfer_q != CNT_MAX) begin
                    xfer_q <= xfer_q + CNT_W'(1);
                end
            end
            occ_q <= occ_q + 2'(inflight_q) - 2'(pop_c);
        end
    end

endmodule

// File: rtl/cov_stream_source.sv
// Streams one image worth of x and y samples plus the latched x mean, then pulses done.
module cov_stream_source
    import cov_stream_source_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = DEFAULT_NUM_INPUTS,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  word_t               mean_x,
    output logic                busy,
    output logic                done,
    cov_stream_source_if.master bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_nxt;
    logic               accept_c;
    logic               run_c;
    logic               x_complete_c;
    logic               y_complete_c;
    word_t              u_x_q;
    logic               u_x_valid_q;

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        state_nxt = state_q;
        accept_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    accept_c  = 1'b1;
                end
            end
            ST_RUN: begin
                if (x_complete_c && y_complete_c) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            u_x_q       <= '0;
            u_x_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            busy        <= (state_nxt == ST_RUN);
            done        <= (state_nxt == ST_DONE);
            u_x_valid_q <= (state_nxt == ST_RUN);
            if (accept_c) begin
                u_x_q <= mean_x;
            end
        end
    end

    assign run_c         = (state_q == ST_RUN);
    assign bus.u_x       = u_x_q;
    assign bus.u_x_valid = u_x_valid_q;

    stream_fetch_channel #(
        .NUM_INPUTS (NUM_INPUTS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) x_chan (
        .clk        (clk),
        .clr        (clr),
        .flush      (accept_c),
        .run        (run_c),
        .rd_en      (bus.x_rd_en),
        .addr       (bus.x_addr),
        .rd_data    (bus.x_rd_data),
        .data       (bus.in_x),
        .valid      (bus.in_x_valid),
        .ready      (bus.in_x_ready),
        .complete_c (x_complete_c)
    );

    stream_fetch_channel #(
        .NUM_INPUTS (NUM_INPUTS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) y_chan (
        .clk        (clk),
        .clr        (clr),
        .flush      (accept_c),
        .run        (run_c),
        .rd_en      (bus.y_rd_en),
        .addr       (bus.y_addr),
        .rd_data    (bus.y_rd_data),
        .data       (bus.in_y),
        .valid      (bus.in_y_valid),
        .ready      (bus.in_y_ready),
        .complete_c (y_complete_c)
    );

endmodule

// File: tb/tb_cov_stream_source.sv
// Bench for cov_stream_source: cycle-exact table on a 4-sample instance, randomized
// handshakes and corner sequences on a 784-sample instance against an in-order stream model.
module tb_cov_stream_source;
    import cov_stream_source_pkg::*;

    localparam int N_S = 4;
    localparam int N_L = 784;

    logic  clk = 1'b0;
    logic  clr;
    logic  start_s;
    logic  start_l;
    word_t mean_x;
    logic  s_busy, s_done, l_busy, l_done;

    word_t x_mem [1024];
    word_t y_mem [1024];

    int vectors    = 0;
    int miscompares = 0;

    cov_stream_source_if #(.ADDR_WIDTH(2))  sbus ();
    cov_stream_source_if #(.ADDR_WIDTH(10)) lbus ();

    cov_stream_source #(.NUM_INPUTS(N_S), .ADDR_WIDTH(2)) dut_s (
        .clk(clk), .clr(clr), .start(start_s), .mean_x(mean_x),
        .busy(s_busy), .done(s_done), .bus(sbus)
    );

    cov_stream_source #(.NUM_INPUTS(N_L), .ADDR_WIDTH(10)) dut_l (
        .clk(clk), .clr(clr), .start(start_l), .mean_x(mean_x),
        .busy(l_busy), .done(l_done), .bus(lbus)
    );

    always #5 clk = ~clk;

    // Sample buffers: data is presented while rd_en is high, garbage otherwise.
    assign sbus.x_rd_data = sbus.x_rd_en ? x_mem[10'(sbus.x_addr)] : 32'hDEAD_BEEF;
    assign sbus.y_rd_data = sbus.y_rd_en ? y_mem[10'(sbus.y_addr)] : 32'hDEAD_BEEF;
    assign lbus.x_rd_data = lbus.x_rd_en ? x_mem[lbus.x_addr] : 32'hDEAD_BEEF;
    assign lbus.y_rd_data = lbus.y_rd_en ? y_mem[lbus.y_addr] : 32'hDEAD_BEEF;
    assign sbus.in_x_ready = 1'b1;
    assign sbus.in_y_ready = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready generator for the large instance: 0 = low, 1 = high, 2 = random.
    logic [1:0] x_mode = 2'd1;
    logic [1:0] y_mode = 2'd1;
    always @(posedge clk) begin
        #1;
        lbus.in_x_ready = (x_mode == 2'd2) ? 1'($urandom_range(0, 1)) : x_mode[0];
        lbus.in_y_ready = (y_mode == 2'd2) ? 1'($urandom_range(0, 1)) : y_mode[0];
    end

    // Reference model: each run must deliver mem[0..N-1] in order on each channel.
    int    xi = 0;
    int    yi = 0;
    int    done_cnt = 0;
    word_t exp_mean = '0;
    logic  px_v = 1'b0, px_r = 1'b0, py_v = 1'b0, py_r = 1'b0, p_clr = 1'b1;
    word_t px_d = '0, py_d = '0;

    always @(negedge clk) begin
        if (lbus.in_x_valid && lbus.in_x_ready) begin
            if (xi < N_L) chk($sformatf("x_order[%0d]", xi), lbus.in_x, x_mem[xi]);
            else          chk("x_extra_xfer", 64'(xi), 64'(N_L - 1));
            xi++;
        end
        if (lbus.in_y_valid && lbus.in_y_ready) begin
            if (yi < N_L) chk($sformatf("y_order[%0d]", yi), lbus.in_y, y_mem[yi]);
            else          chk("y_extra_xfer", 64'(yi), 64'(N_L - 1));
            yi++;
        end
        if (px_v && !px_r && !p_clr) begin
            chk("x_hold_valid", lbus.in_x_valid, 1);
            chk("x_hold_data", lbus.in_x, px_d);
        end
        if (py_v && !py_r && !p_clr) begin
            chk("y_hold_valid", lbus.in_y_valid, 1);
            chk("y_hold_data", lbus.in_y, py_d);
        end
        chk("u_x_valid_vs_busy", lbus.u_x_valid, l_busy);
        if (lbus.u_x_valid) chk("u_x_latched", lbus.u_x, exp_mean);
        if (l_done) begin
            done_cnt++;
            chk("done_x_count", 64'(xi), 64'(N_L));
            chk("done_y_count", 64'(yi), 64'(N_L));
        end
        px_v = lbus.in_x_valid; px_r = lbus.in_x_ready; px_d = lbus.in_x;
        py_v = lbus.in_y_valid; py_r = lbus.in_y_ready; py_d = lbus.in_y;
        p_clr = clr;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input word_t m);
        step();
        mean_x   = m;
        start_l  = 1'b1;
        exp_mean = m;
        xi = 0;
        yi = 0;
        step();
        start_l = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            sample();
            seen = l_done;
        end
        chk("done_timeout", seen, 1);
    endtask

    typedef struct {
        logic start, busy, done, uv, xv, yv, rd;
        int   idx;
        int   addr;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] f, input int idx, input int addr);
        vec_t v;
        {v.start, v.busy, v.done, v.uv, v.xv, v.yv, v.rd} = f;
        v.idx  = idx;
        v.addr = addr;
        return v;
    endfunction

    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        word_t held;
        int    dc;
        for (int i = 0; i < 1024; i++) begin
            x_mem[i] = 32'($urandom);
            y_mem[i] = 32'($urandom);
        end
        clr = 1'b1; start_s = 1'b0; start_l = 1'b0; mean_x = '0;
        repeat (3) step();
        clr = 1'b0;
        sample();

        // Reset state of both instances
        chk("rst_s_busy", s_busy, 0);         chk("rst_s_done", s_done, 0);
        chk("rst_s_xv", sbus.in_x_valid, 0);  chk("rst_s_yv", sbus.in_y_valid, 0);
        chk("rst_s_in_x", sbus.in_x, 0);      chk("rst_s_u_x", sbus.u_x, 0);
        chk("rst_l_busy", l_busy, 0);         chk("rst_l_rd", lbus.x_rd_en, 0);
        chk("rst_l_in_y", lbus.in_y, 0);      chk("rst_l_uv", lbus.u_x_valid, 0);

        // Cycle-exact run, N=4, readies high; first valid 1+RD_LATENCY cycles after start
        //                flags: start busy done uv xv yv rd
        tbl[0] = mk(7'b1000000, -1, -1);
        tbl[1] = mk(7'b0101001, -1,  0);
        tbl[2] = mk(7'b0101111,  0,  1);
        tbl[3] = mk(7'b0101111,  1,  2);
        tbl[4] = mk(7'b0101111,  2,  3);
        tbl[5] = mk(7'b0101110,  3, -1);
        tbl[6] = mk(7'b0010000, -1, -1);
        tbl[7] = mk(7'b0000000, -1, -1);
        for (int i = 0; i < 8; i++) begin
            step();
            start_s = tbl[i].start;
            mean_x  = 32'h3F80_0000;
            sample();
            chk($sformatf("s_busy[%0d]", i), s_busy, tbl[i].busy);
            chk($sformatf("s_done[%0d]", i), s_done, tbl[i].done);
            chk($sformatf("s_uv[%0d]", i), sbus.u_x_valid, tbl[i].uv);
            chk($sformatf("s_xv[%0d]", i), sbus.in_x_valid, tbl[i].xv);
            chk($sformatf("s_yv[%0d]", i), sbus.in_y_valid, tbl[i].yv);
            chk($sformatf("s_xrd[%0d]", i), sbus.x_rd_en, tbl[i].rd);
            chk($sformatf("s_yrd[%0d]", i), sbus.y_rd_en, tbl[i].rd);
            if (tbl[i].idx >= 0) begin
                chk($sformatf("s_in_x[%0d]", i), sbus.in_x, x_mem[tbl[i].idx]);
                chk($sformatf("s_in_y[%0d]", i), sbus.in_y, y_mem[tbl[i].idx]);
            end
            if (tbl[i].addr >= 0) chk($sformatf("s_xaddr[%0d]", i), 64'(sbus.x_addr), 64'(tbl[i].addr));
            if (tbl[i].uv) chk($sformatf("s_u_x[%0d]", i), sbus.u_x, 32'h3F80_0000);
            if (i == 1 + RD_LATENCY) chk("s_first_valid", sbus.in_x_valid, 1);
        end

        // Random ready toggling on both channels
        x_mode = 2'd2; y_mode = 2'd2;
        launch(32'($urandom));
        wait_done(20000);
        x_mode = 2'd1; y_mode = 2'd1;
        repeat (4) step();
        sample();
        chk("rand_x_total", 64'(xi), 64'(N_L));
        chk("rand_y_total", 64'(yi), 64'(N_L));
        chk("rand_idle_busy", l_busy, 0);

        // y stalled for 10 cycles near the end: x completes, done waits for y
        launch(32'h4000_0000);
        for (int k = 0; k < 2000 && xi < N_L - 6; k++) step();
        y_mode = 2'd0;
        for (int k = 0; k < 10; k++) begin
            step();
            sample();
            if (k == 0) held = lbus.in_y;
            chk($sformatf("stall_y_valid[%0d]", k), lbus.in_y_valid, 1);
            chk($sformatf("stall_y_hold[%0d]", k), lbus.in_y, held);
            chk($sformatf("stall_no_done[%0d]", k), l_done, 0);
        end
        chk("stall_x_finished", 64'(xi), 64'(N_L));
        chk("stall_y_pending", (yi < N_L), 1);
        y_mode = 2'd1;
        wait_done(100);
        chk("stall_y_total", 64'(yi), 64'(N_L));

        // clr during the 3rd transfer aborts the run; a new start replays from 0
        repeat (3) step();
        launch(32'h1234_5678);
        repeat (3) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        dc  = done_cnt;
        sample();
        chk("abort_xfers", 64'(xi), 64'd3);
        chk("abort_in_x", lbus.in_x, 0);          chk("abort_in_y", lbus.in_y, 0);
        chk("abort_xv", lbus.in_x_valid, 0);      chk("abort_yv", lbus.in_y_valid, 0);
        chk("abort_u_x", lbus.u_x, 0);            chk("abort_uv", lbus.u_x_valid, 0);
        chk("abort_xrd", lbus.x_rd_en, 0);        chk("abort_busy", l_busy, 0);
        repeat (20) step();
        chk("abort_no_done", 64'(done_cnt), 64'(dc));
        launch(32'h0BAD_F00D);
        sample();
        chk("replay_rd", lbus.x_rd_en, 1);
        chk("replay_addr", 64'(lbus.x_addr), 64'd0);
        wait_done(1000);
        chk("replay_x_total", 64'(xi), 64'(N_L));

        // start re-asserted during RUN with a different mean
        repeat (3) step();
        launch(32'hAAAA_5555);
        repeat (50) step();
        mean_x  = 32'h5555_AAAA;
        start_l = 1'b1;
        repeat (3) step();
        start_l = 1'b0;
        sample();
        chk("rerun_u_x", lbus.u_x, 32'hAAAA_5555);
        wait_done(1000);
        repeat (3) step();
        sample();
        chk("rerun_x_total", 64'(xi), 64'(N_L));
        chk("rerun_y_total", 64'(yi), 64'(N_L));
        chk("rerun_u_x_hold", lbus.u_x, 32'hAAAA_5555);

        // clr and start together: clr wins
        step();
        clr = 1'b1; start_l = 1'b1; mean_x = 32'hC0FF_EE00;
        step();
        clr = 1'b0; start_l = 1'b0;
        sample();
        chk("clrstart_busy", l_busy, 0);
        chk("clrstart_uv", lbus.u_x_valid, 0);
        chk("clrstart_u_x", lbus.u_x, 0);
        chk("clrstart_rd", lbus.x_rd_en, 0);
        repeat (3) step();
        sample();
        chk("clrstart_busy_later", l_busy, 0);
        chk("clrstart_xv_later", lbus.in_x_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
